// File: rtl/gpio_pkg.sv
// Shared constants and address-decode helper for the memory-mapped GPIO port.
package gpio_pkg;

    localparam logic [2:0] GPIO_DIR      = 3'd0;
    localparam logic [2:0] GPIO_DATA     = 3'd1;
    localparam logic [2:0] GPIO_IRQ_EN   = 3'd2;
    localparam logic [2:0] GPIO_EDGE     = 3'd3;
    localparam logic [2:0] GPIO_FLAG     = 3'd4;
    localparam logic [2:0] GPIO_DEBOUNCE = 3'd5;

    localparam int GPIO_NREGS = 6;

    // deb_q refills 3 cycles after reset release; one more lets deb_q_prev catch up
    localparam logic [2:0] GPIO_ARM_CYC = 3'd4;

    function automatic logic gpio_hit(
        input logic [23:0] addr,
        input logic [23:0] base,
        input logic [2:0]  off
    );
        return addr == (base + {21'd0, off});
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin two-flop synchroniser followed by a stable-cycle debounce counter.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEB_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pin_i,
    input  logic [DEB_W-1:0] n_i,
    output logic             deb_o
);

    logic             s1_q;
    logic             s2_q;
    logic             deb_q;
    logic             deb_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q >= n_i) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= pin_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: direction/data/IRQ registers, debounced inputs,
// edge-detect flags with write-1-to-clear and an OR-bus-safe read port.
module gpio_port
    import gpio_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = 24'h2060,
    parameter int          WIDTH     = 8,
    parameter int          DEB_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_write,
    input  logic             bus_read,
    input  logic [23:0]      bus_address_in,
    input  logic [7:0]       bus_data_in,
    output logic [7:0]       bus_data_out,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam int NW = (DEB_W < 8) ? DEB_W : 8;

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [NW-1:0]    debn_q, debn_d;
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       arm_q, arm_d;

    logic [GPIO_NREGS-1:0] hit;
    logic [GPIO_NREGS-1:0] we;
    logic [WIDTH-1:0]      wdat;
    logic [WIDTH-1:0]      deb;
    logic [WIDTH-1:0]      din;
    logic [WIDTH-1:0]      edge_hit;
    logic [WIDTH-1:0]      set;
    logic [DEB_W-1:0]      n_ext;
    logic                  armed;
    logic [7:0]            rdata;

    always_comb begin
        for (int k = 0; k < GPIO_NREGS; k++) begin
            hit[k] = gpio_hit(bus_address_in, BASE_ADDR, 3'(k));
        end
    end

    assign we    = hit & {GPIO_NREGS{bus_write}};
    assign wdat  = bus_data_in[WIDTH-1:0];
    assign n_ext = DEB_W'(debn_q);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .DEB_W (DEB_W)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .pin_i (pin_in[i]),
            .n_i   (n_ext),
            .deb_o (deb[i])
        );
    end

    assign din      = (dir_q & dout_q) | (~dir_q & deb);
    assign edge_hit = ~dir_q & ((edge_q & deb & ~prev_q)
                              | (~edge_q & ~deb & prev_q));
    assign armed    = (arm_q == GPIO_ARM_CYC);
    assign set      = armed ? edge_hit : '0;

    always_comb begin
        dir_d  = we[GPIO_DIR]      ? wdat : dir_q;
        dout_d = we[GPIO_DATA]     ? wdat : dout_q;
        ien_d  = we[GPIO_IRQ_EN]   ? wdat : ien_q;
        edge_d = we[GPIO_EDGE]     ? wdat : edge_q;
        debn_d = we[GPIO_DEBOUNCE] ? bus_data_in[NW-1:0] : debn_q;
        // a new edge in the same cycle as its clear keeps the flag set
        flag_d = (flag_q & ~(we[GPIO_FLAG] ? wdat : '0)) | set;
        arm_d  = armed ? arm_q : arm_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q  <= '0;
            dout_q <= '0;
            ien_q  <= '0;
            edge_q <= '0;
            flag_q <= '0;
            debn_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            dir_q  <= dir_d;
            dout_q <= dout_d;
            ien_q  <= ien_d;
            edge_q <= edge_d;
            flag_q <= flag_d;
            debn_q <= debn_d;
            prev_q <= deb;
            arm_q  <= arm_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (bus_read) begin
            unique case (1'b1)
                hit[GPIO_DIR]:      rdata = 8'(dir_q);
                hit[GPIO_DATA]:     rdata = 8'(din);
                hit[GPIO_IRQ_EN]:   rdata = 8'(ien_q);
                hit[GPIO_EDGE]:     rdata = 8'(edge_q);
                hit[GPIO_FLAG]:     rdata = 8'(flag_q);
                hit[GPIO_DEBOUNCE]: rdata = 8'(debn_q);
                default:            rdata = 8'h00;
            endcase
        end
    end

    assign bus_data_out = rdata;
    assign pin_out      = dout_q;
    assign pin_oe       = dir_q;
    assign irq          = |(flag_q & ien_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register vector table plus multi-cycle sequences.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [7:0]  pin_in;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic        irq;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_port #(
        .BASE_ADDR (24'h2060),
        .WIDTH     (8),
        .DEB_W     (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .pin_in         (pin_in),
        .pin_out        (pin_out),
        .pin_oe         (pin_oe),
        .irq            (irq)
    );

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  pin;
        int          waitc;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_oe;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        tick();
        bus_write      = 1'b0;
    endtask

    task automatic chk_rd(input string nm, input logic [23:0] a,
                          input logic [7:0] exp);
        bus_address_in = a;
        bus_read       = 1'b1;
        #1;
        chk(nm, bus_data_out, exp);
        bus_read       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic edge7(input logic [7:0] lvl, input int n);
        pin_in = lvl;
        repeat (n) tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus_write      = 1'b0;
        bus_read       = 1'b0;
        bus_address_in = 24'h0;
        bus_data_in    = 8'h00;
        pin_in         = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        //        wr  addr      wdata  pin    wt rd     oe     out
        vq.push_back('{0, 24'h2060, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{0, 24'h2061, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{0, 24'h2062, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{0, 24'h2063, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{0, 24'h2064, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{0, 24'h2065, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{0, 24'h2070, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00});
        vq.push_back('{1, 24'h2060, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h00});
        vq.push_back('{1, 24'h2061, 8'hA5, 8'h00, 0, 8'h05, 8'h0F, 8'hA5});
        vq.push_back('{0, 24'h2061, 8'h00, 8'hF0, 2, 8'h05, 8'h0F, 8'hA5});
        vq.push_back('{0, 24'h2061, 8'h00, 8'hF0, 1, 8'hF5, 8'h0F, 8'hA5});
        vq.push_back('{0, 24'h2064, 8'h00, 8'hF0, 2, 8'h00, 8'h0F, 8'hA5});
        vq.push_back('{1, 24'h2063, 8'h3C, 8'hF0, 0, 8'h3C, 8'h0F, 8'hA5});
        vq.push_back('{1, 24'h2065, 8'h07, 8'hF0, 0, 8'h07, 8'h0F, 8'hA5});
        vq.push_back('{1, 24'h2065, 8'h00, 8'hF0, 0, 8'h00, 8'h0F, 8'hA5});
        vq.push_back('{1, 24'h2063, 8'h00, 8'hF0, 0, 8'h00, 8'h0F, 8'hA5});
        vq.push_back('{1, 24'h2062, 8'h81, 8'hF0, 0, 8'h81, 8'h0F, 8'hA5});
        vq.push_back('{1, 24'h2062, 8'h00, 8'hF0, 0, 8'h00, 8'h0F, 8'hA5});

        for (int i = 0; i < vq.size(); i++) begin
            pin_in = vq[i].pin;
            if (vq[i].wr) wr(vq[i].addr, vq[i].wdata);
            repeat (vq[i].waitc) tick();
            chk_rd($sformatf("vec%0d rd", i), vq[i].addr, vq[i].exp_rd);
            chk($sformatf("vec%0d oe", i), pin_oe, vq[i].exp_oe);
            chk($sformatf("vec%0d out", i), pin_out, vq[i].exp_out);
        end

        bus_address_in = 24'h2060;
        bus_read       = 1'b0;
        #1;
        chk("noread", bus_data_out, 8'h00);

        // debounce N=4 with a 2-cycle glitch before the stable level
        pin_in = 8'h00;
        do_reset();
        repeat (5) tick();
        wr(24'h2065, 8'h04);
        edge7(8'h80, 2);
        edge7(8'h00, 5);
        edge7(8'h80, 6);
        chk_rd("deb early", 24'h2061, 8'h00);
        tick();
        chk_rd("deb commit", 24'h2061, 8'h80);
        chk_rd("deb noflag", 24'h2064, 8'h00);

        // rising-edge flag, irq, and W1C
        wr(24'h2065, 8'h00);
        wr(24'h2063, 8'h80);
        wr(24'h2062, 8'h80);
        edge7(8'h00, 5);
        chk_rd("fall noflag", 24'h2064, 8'h00);
        chk("fall noirq", 8'(irq), 8'h00);
        edge7(8'h80, 3);
        chk_rd("rise pre", 24'h2064, 8'h00);
        tick();
        chk_rd("rise flag", 24'h2064, 8'h80);
        chk("rise irq", 8'(irq), 8'h01);
        wr(24'h2064, 8'h80);
        chk_rd("w1c flag", 24'h2064, 8'h00);
        chk("w1c irq", 8'(irq), 8'h00);

        // clear colliding with a new edge: set wins
        edge7(8'h00, 5);
        edge7(8'h80, 4);
        chk_rd("pre flag", 24'h2064, 8'h80);
        edge7(8'h00, 5);
        edge7(8'h80, 3);
        wr(24'h2064, 8'h80);
        chk_rd("coll flag", 24'h2064, 8'h80);
        chk("coll irq", 8'(irq), 8'h01);
        wr(24'h2064, 8'h80);
        chk_rd("coll clr", 24'h2064, 8'h00);

        // reset with pins held high must not raise flags
        edge7(8'hFF, 5);
        reset = 1'b1;
        tick();
        chk("rst oe", pin_oe, 8'h00);
        chk("rst out", pin_out, 8'h00);
        chk("rst irq", 8'(irq), 8'h00);
        chk_rd("rst flag", 24'h2064, 8'h00);
        reset = 1'b0;
        wr(24'h2063, 8'hFF);
        repeat (10) tick();
        chk_rd("arm flag", 24'h2064, 8'h00);
        wr(24'h2062, 8'hFF);
        edge7(8'h00, 5);
        edge7(8'hFF, 4);
        chk_rd("all flag", 24'h2064, 8'hFF);
        chk("all irq", 8'(irq), 8'h01);

        // output pins never raise flags
        wr(24'h2064, 8'hFF);
        chk_rd("all clr", 24'h2064, 8'h00);
        wr(24'h2060, 8'h80);
        edge7(8'h00, 5);
        edge7(8'hFF, 4);
        chk_rd("dir flag", 24'h2064, 8'h7F);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
